// File: rtl/cache_sel_pkg.sv
// Shared types and constants for the cache selector launch stage.
package cache_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_LAUNCH   = 2'd2,
        ST_WAIT_ACK = 2'd3
    } sel_state_t;

    localparam int DEF_TAG_W = 20;

    // Route encoding: hit drives valid0, miss/replacement drives valid1.
    localparam logic ROUTE_HIT  = 1'b0;
    localparam logic ROUTE_MISS = 1'b1;

endpackage

// File: rtl/sync_toggle_det.sv
// Multi-flop synchroniser for a two-phase toggle input, with an XOR edge
// detector that emits a one-cycle pulse per transition.
module sync_toggle_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/cache_sel_launch.sv
// Launch stage ahead of the 2-way cache selector: registers one-hot route valids,
// fires a two-phase o_drive and holds until fire and free both return.
// Optional watchdog enabled by defining CACHE_SEL_TIMEOUT_EN.
module cache_sel_launch
    import cache_sel_pkg::*;
#(
    parameter int TAG_W       = DEF_TAG_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_hit,
    input  logic [TAG_W-1:0] req_tag,
    output logic             o_drive,
    input  logic             i_fire,
    input  logic             i_free,
    output logic             valid0,
    output logic             valid1,
    output logic [TAG_W-1:0] route_tag,
    output logic             busy,
    output logic             timeout_err,
    output sel_state_t       state_dbg
);

    sel_state_t state_q, state_d;
    logic fire_pulse, free_pulse;
    logic fire_seen_q, free_seen_q;
    logic fire_now, free_now;
    logic accept, launch, done;
    logic route_sel;

    sync_toggle_det #(.SYNC_STAGES(SYNC_STAGES)) u_fire_det (
        .clk(clk), .rst(rst), .async_in(i_fire), .pulse(fire_pulse)
    );
    sync_toggle_det #(.SYNC_STAGES(SYNC_STAGES)) u_free_det (
        .clk(clk), .rst(rst), .async_in(i_free), .pulse(free_pulse)
    );

    // An ack arriving in the same cycle counts as already seen.
    assign fire_now  = fire_seen_q | fire_pulse;
    assign free_now  = free_seen_q | free_pulse;
    assign route_sel = req_hit ? ROUTE_HIT : ROUTE_MISS;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        launch  = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM:    state_d = ST_LAUNCH;
            ST_LAUNCH: begin
                launch  = 1'b1;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (fire_now && free_now) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid0      <= 1'b0;
            valid1      <= 1'b0;
            route_tag   <= '0;
            o_drive     <= 1'b0;
            fire_seen_q <= 1'b0;
            free_seen_q <= 1'b0;
        end else begin
            if (accept) begin
                valid0    <= (route_sel == ROUTE_HIT);
                valid1    <= (route_sel == ROUTE_MISS);
                route_tag <= req_tag;
            end
            if (launch) begin
                o_drive     <= ~o_drive;
                fire_seen_q <= 1'b0;
                free_seen_q <= 1'b0;
            end
            // Ack edges outside WAIT_ACK are protocol errors and are dropped.
            if (state_q == ST_WAIT_ACK) begin
                fire_seen_q <= fire_now & ~done;
                free_seen_q <= free_now & ~done;
            end
            if (done) begin
                valid0 <= 1'b0;
                valid1 <= 1'b0;
            end
        end
    end

    assign req_ready = rst && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

`ifdef CACHE_SEL_TIMEOUT_EN
    localparam int TO_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_err_q;

    assign to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else if (launch) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_WAIT_ACK) begin
            to_cnt_q <= to_cnt_d;
            if (to_cnt_d >= TO_LIMIT) to_err_q <= 1'b1;
        end
    end

    assign timeout_err = to_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_cache_sel_launch.sv
// Directed self-checking bench for cache_sel_launch with a simple selector ack model.
module tb_cache_sel_launch;
    import cache_sel_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_hit;
    logic [19:0] req_tag;
    logic        o_drive;
    logic        i_fire;
    logic        i_free;
    logic        valid0;
    logic        valid1;
    logic [19:0] route_tag;
    logic        busy;
    logic        timeout_err;
    sel_state_t  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [19:0] exp_q[$];

    cache_sel_launch #(.TAG_W(20), .SYNC_STAGES(2), .TIMEOUT_CYC(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_hit(req_hit), .req_tag(req_tag),
        .o_drive(o_drive), .i_fire(i_fire), .i_free(i_free),
        .valid0(valid0), .valid1(valid1), .route_tag(route_tag),
        .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string lbl, input logic exp_ready);
        check({lbl, "_ready"}, req_ready, exp_ready);
        check({lbl, "_drive"}, o_drive, 0);
        check({lbl, "_v0"}, valid0, 0);
        check({lbl, "_v1"}, valid1, 0);
        check({lbl, "_tag"}, route_tag, 0);
        check({lbl, "_busy"}, busy, 0);
        check({lbl, "_tmo"}, timeout_err, 0);
        check({lbl, "_state"}, state_dbg, ST_IDLE);
    endtask

    // driver: present a request and wait (bounded) until it is accepted
    task automatic send_req(input logic hit, input logic [19:0] tag, output int waited);
        req_valid = 1'b1;
        req_hit   = hit;
        req_tag   = tag;
        waited    = -1;
        for (int i = 0; i < 100; i++) begin
            if (req_ready === 1'b1) begin
                waited = i;
                break;
            end
            @(negedge clk);
        end
        if (waited < 0) begin
            check("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
        end else begin
            exp_q.push_back(tag);
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // called in the cycle after accept; ends in the first WAIT_ACK cycle
    task automatic launch_checks(input string lbl, input logic hit, input logic drive_before);
        logic [19:0] exp_tag;
        exp_tag = (exp_q.size() > 0) ? exp_q.pop_front() : 20'h0;
        check({lbl, "_v0"}, valid0, hit);
        check({lbl, "_v1"}, valid1, !hit);
        check({lbl, "_tag"}, route_tag, exp_tag);
        check({lbl, "_busy"}, busy, 1);
        check({lbl, "_ready_lo"}, req_ready, 0);
        @(negedge clk);
        check({lbl, "_drive_hold"}, o_drive, drive_before);
        @(negedge clk);
        check({lbl, "_drive_tgl"}, o_drive, !drive_before);
        check({lbl, "_wait_st"}, state_dbg, ST_WAIT_ACK);
    endtask

    // selector ack model: toggle fire/free at given cycle offsets, watch valids hold
    task automatic acks(input string lbl, input int fd, input int fr, input int span,
                        input logic ev0, input logic ev1);
        logic bad;
        bad = 1'b0;
        for (int c = 1; c <= span; c++) begin
            @(negedge clk);
            if (valid0 !== ev0 || valid1 !== ev1 || state_dbg !== ST_WAIT_ACK) bad = 1'b1;
            if (c == fd) i_fire = ~i_fire;
            if (c == fr) i_free = ~i_free;
        end
        check({lbl, "_hold"}, bad, 0);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (state_dbg == ST_IDLE) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int w, w2, c;
        rst = 1'b0; req_valid = 1'b0; req_hit = 1'b0; req_tag = '0;
        i_fire = 1'b0; i_free = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("rst0", 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst0_rel_ready", req_ready, 1);

        // hit request, fire 5 cycles after o_drive, free 2 later
        send_req(1'b1, 20'h00ABC, w);
        check("t1_wait", w, 0);
        launch_checks("t1", 1'b1, 1'b0);
        acks("t1", 5, 7, 7, 1'b1, 1'b0);
        wait_idle(c);
        check("t1_ret", c, 3);
        check("t1_idle_v0", valid0, 0);
        check("t1_idle_v1", valid1, 0);
        check("t1_idle_ready", req_ready, 1);
        check("t1_tag_kept", route_tag, 20'h00ABC);

        // miss request, second request held until both acks land
        send_req(1'b0, 20'h5A5A5, w);
        launch_checks("t2", 1'b0, 1'b1);
        fork
            acks("t2", 3, 4, 4, 1'b0, 1'b1);
            send_req(1'b1, 20'h0F00D, w2);
        join
        check("t2_held", w2, 7);

        // second launch with fire and free in the same cycle
        launch_checks("t3", 1'b1, 1'b0);
        acks("t3", 2, 2, 2, 1'b1, 1'b0);
        wait_idle(c);
        check("t3_ret", c, 3);
        @(negedge clk);
        check("t3_stay_idle", state_dbg, ST_IDLE);
        check("t3_drive", o_drive, 1);

        // reversed order: free first, fire much later
        send_req(1'b0, 20'h12345, w);
        launch_checks("t4", 1'b0, 1'b1);
        acks("t4", 6, 1, 6, 1'b0, 1'b1);
        wait_idle(c);
        check("t4_ret", c, 3);

        // reset in the middle of WAIT_ACK with an ack in flight
        send_req(1'b1, 20'hFFFFF, w);
        launch_checks("t5", 1'b1, 1'b0);
        i_fire = ~i_fire;
        @(negedge clk);
        rst = 1'b0; i_fire = 1'b0; i_free = 1'b0;
        @(negedge clk);
        check_reset_vals("t5_rst", 0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rel_ready", req_ready, 1);
        check("t5_rel_busy", busy, 0);

        // no spurious ack after reset: launch stays waiting until real acks arrive
        send_req(1'b0, 20'h0BEEF, w);
        launch_checks("t6", 1'b0, 1'b0);
        acks("t6_noack", 0, 0, 8, 1'b0, 1'b1);
        acks("t6", 1, 1, 1, 1'b0, 1'b1);
        wait_idle(c);
        check("t6_ret", c, 3);

`ifdef CACHE_SEL_TIMEOUT_EN
        // watchdog: no acks, flag after 10 WAIT_ACK cycles and sticky until reset
        send_req(1'b1, 20'h00777, w);
        launch_checks("t7", 1'b1, 1'b1);
        acks("t7a", 0, 0, 9, 1'b1, 1'b0);
        check("t7_tmo_lo", timeout_err, 0);
        acks("t7b", 0, 0, 1, 1'b1, 1'b0);
        check("t7_tmo_hi", timeout_err, 1);
        acks("t7c", 0, 0, 5, 1'b1, 1'b0);
        check("t7_tmo_sticky", timeout_err, 1);
        rst = 1'b0; i_fire = 1'b0; i_free = 1'b0;
        @(negedge clk);
        check_reset_vals("t7_rst", 0);
        rst = 1'b1;
        @(negedge clk);
`else
        check("tmo_off", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
